// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle fetch/decode/execute controller for the 16-bit CPU (PC, IR, flags, datapath strobes).
// Optional retired-instruction counter built only when CTRL_INSTR_CNT_EN is defined.
module cpu_ctrl_fsm #(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic [15:0] mem_addr,
   output logic        mem_rd,
   output logic        mem_wr,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_rdata,
   input  logic [15:0] reg_p,
   output logic [2:0]  rb_pa,
   output logic        rb_rdr,
   output logic [2:0]  rb_wp,
   output logic        rb_wrr,
   output logic        wb_sel,
   output logic        x_ld,
   output logic        y_ld,
   output logic [2:0]  alu_fsel,
   output logic        alu_ld,
   input  logic        alu_c,
   input  logic        alu_v,
   input  logic        alu_s,
   input  logic        alu_z,
   output logic [3:0]  flags,
   output logic [15:0] pc,
   output logic [15:0] ir,
   output logic        halted,
   output logic        illegal_op,
   output logic [15:0] instr_cnt
);

   typedef enum logic [3:0] {
      BOOT   = 4'd0, FETCH = 4'd1, DECODE = 4'd2, RD_A   = 4'd3, RD_B = 4'd4,
      EXEC   = 4'd5, WB    = 4'd6, MEM    = 4'd7, MEM_WB = 4'd8, HALT = 4'd9
   } state_t;

   localparam logic [3:0] OP_NOP = 4'h0, OP_ADD = 4'h1, OP_SUB = 4'h2, OP_AND = 4'h3,
                          OP_OR  = 4'h4, OP_NEG = 4'h5, OP_CMP = 4'h6, OP_LD  = 4'h7,
                          OP_ST  = 4'h8, OP_JMP = 4'h9, OP_BZ  = 4'hA, OP_HLT = 4'hF;

   typedef struct packed {
      logic [15:0] mem_addr;
      logic        mem_rd;
      logic        mem_wr;
      logic [15:0] mem_wdata;
      logic [2:0]  rb_pa;
      logic        rb_rdr;
      logic [2:0]  rb_wp;
      logic        rb_wrr;
      logic        wb_sel;
      logic        x_ld;
      logic        y_ld;
      logic [2:0]  alu_fsel;
      logic        alu_ld;
   } ctrl_t;

   function automatic logic is_illegal(input logic [3:0] op);
      logic ill;
      case (op)
         4'hB, 4'hC, 4'hD, 4'hE: ill = 1'b1;
         default:                ill = 1'b0;
      endcase
      return ill;
   endfunction

   function automatic logic [2:0] alu_func(input logic [3:0] op);
      logic [2:0] fs;
      case (op)
         OP_ADD:  fs = 3'b000;
         OP_SUB:  fs = 3'b001;
         OP_AND:  fs = 3'b010;
         OP_OR:   fs = 3'b011;
         OP_NEG:  fs = 3'b100;
         OP_CMP:  fs = 3'b101;
         default: fs = 3'b000;
      endcase
      return fs;
   endfunction

   // Strobes for a given state; ins_v is ir[15:3] = {op, rd, rs1, rs2}.
   function automatic ctrl_t ctrl_decode(input state_t st, input logic [12:0] ins_v,
                                         input logic [15:0] pc_v, input logic [15:0] a_v,
                                         input logic [15:0] b_v);
      ctrl_t c;
      c = '0;
      case (st)
         FETCH: begin
            c.mem_rd   = 1'b1;
            c.mem_addr = pc_v & 16'hFFFE;
         end
         RD_A: begin
            c.rb_pa  = ins_v[5:3];
            c.rb_rdr = 1'b1;
            c.x_ld   = 1'b1;
         end
         RD_B: begin
            c.rb_pa  = ins_v[2:0];
            c.rb_rdr = 1'b1;
            c.y_ld   = 1'b1;
         end
         EXEC: begin
            c.alu_fsel = alu_func(ins_v[12:9]);
            c.alu_ld   = 1'b1;
         end
         WB: begin
            c.alu_fsel = alu_func(ins_v[12:9]);
            c.alu_ld   = 1'b1;
            c.rb_wp    = ins_v[8:6];
            c.rb_wrr   = 1'b1;
            c.wb_sel   = 1'b0;
         end
         MEM: begin
            c.mem_addr = a_v & 16'hFFFE;
            if (ins_v[12:9] == OP_LD) begin
               c.mem_rd = 1'b1;
            end else begin
               c.mem_wr    = 1'b1;
               c.mem_wdata = b_v;
            end
         end
         MEM_WB: begin
            c.rb_wp  = ins_v[8:6];
            c.rb_wrr = 1'b1;
            c.wb_sel = 1'b1;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

   state_t      state_r, state_nxt_s;
   logic [15:0] pc_r, pc_nxt_s, ir_r, ir_nxt_s, a_r, a_nxt_s, b_r, b_nxt_s;
   logic [3:0]  flags_r, flags_nxt_s;
   logic [3:0]  op_s, dec_op_s;
   ctrl_t       ctrl_r;
   logic        illegal_r, halted_r;

   assign op_s     = ir_r[15:12];
   assign dec_op_s = mem_rdata[15:12];

   // Next-state and architectural-register update logic.
   always_comb begin
      state_nxt_s = state_r;
      pc_nxt_s    = pc_r;
      ir_nxt_s    = ir_r;
      flags_nxt_s = flags_r;
      a_nxt_s     = a_r;
      b_nxt_s     = b_r;
      case (state_r)
         BOOT:  state_nxt_s = FETCH;
         FETCH: state_nxt_s = DECODE;
         DECODE: begin
            ir_nxt_s = mem_rdata;
            pc_nxt_s = pc_r + 16'd2;
            if (dec_op_s == OP_HLT) begin
               state_nxt_s = HALT;
            end else if ((dec_op_s == OP_NOP) || is_illegal(dec_op_s)) begin
               state_nxt_s = FETCH;
            end else begin
               state_nxt_s = RD_A;
            end
         end
         RD_A: begin
            a_nxt_s = reg_p;
            case (op_s)
               OP_JMP: begin
                  pc_nxt_s    = reg_p & 16'hFFFE;
                  state_nxt_s = FETCH;
               end
               OP_BZ: begin
                  if (flags_r[0]) begin
                     pc_nxt_s = reg_p & 16'hFFFE;
                  end else begin
                     pc_nxt_s = pc_r;
                  end
                  state_nxt_s = FETCH;
               end
               OP_NEG:  state_nxt_s = EXEC;
               OP_LD:   state_nxt_s = MEM;
               default: state_nxt_s = RD_B;
            endcase
         end
         RD_B: begin
            b_nxt_s = reg_p;
            if (op_s == OP_ST) begin
               state_nxt_s = MEM;
            end else begin
               state_nxt_s = EXEC;
            end
         end
         EXEC: begin
            flags_nxt_s = {alu_c, alu_v, alu_s, alu_z};
            if (op_s == OP_CMP) begin
               state_nxt_s = FETCH;
            end else begin
               state_nxt_s = WB;
            end
         end
         WB: state_nxt_s = FETCH;
         MEM: begin
            if (op_s == OP_LD) begin
               state_nxt_s = MEM_WB;
            end else begin
               state_nxt_s = FETCH;
            end
         end
         MEM_WB:  state_nxt_s = FETCH;
         HALT:    state_nxt_s = HALT;
         default: state_nxt_s = BOOT;
      endcase
   end

   // State, architectural registers and registered strobes (decoded from next state).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= BOOT;
         pc_r      <= RESET_PC & 16'hFFFE;
         ir_r      <= 16'h0000;
         flags_r   <= 4'h0;
         a_r       <= 16'h0000;
         b_r       <= 16'h0000;
         ctrl_r    <= '0;
         illegal_r <= 1'b0;
         halted_r  <= 1'b0;
      end else begin
         state_r   <= state_nxt_s;
         pc_r      <= pc_nxt_s;
         ir_r      <= ir_nxt_s;
         flags_r   <= flags_nxt_s;
         a_r       <= a_nxt_s;
         b_r       <= b_nxt_s;
         ctrl_r    <= ctrl_decode(state_nxt_s, ir_nxt_s[15:3], pc_nxt_s, a_nxt_s, b_nxt_s);
         illegal_r <= (state_r == DECODE) && is_illegal(dec_op_s);
         halted_r  <= (state_nxt_s == HALT);
      end
   end

`ifdef CTRL_INSTR_CNT_EN
   logic [15:0] instr_cnt_r;
   logic        retire_s;

   assign retire_s = ((state_nxt_s == FETCH) && (state_r != BOOT)) ||
                     ((state_nxt_s == HALT) && (state_r != HALT));

   // Retired-instruction counter, wraps naturally at 16 bits.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instr_cnt_r <= 16'h0000;
      end else if (retire_s) begin
         instr_cnt_r <= instr_cnt_r + 16'd1;
      end else begin
         instr_cnt_r <= instr_cnt_r;
      end
   end

   assign instr_cnt = instr_cnt_r;
`else
   assign instr_cnt = 16'h0000;
`endif

   assign mem_addr   = ctrl_r.mem_addr;
   assign mem_rd     = ctrl_r.mem_rd;
   assign mem_wr     = ctrl_r.mem_wr;
   assign mem_wdata  = ctrl_r.mem_wdata;
   assign rb_pa      = ctrl_r.rb_pa;
   assign rb_rdr     = ctrl_r.rb_rdr;
   assign rb_wp      = ctrl_r.rb_wp;
   assign rb_wrr     = ctrl_r.rb_wrr;
   assign wb_sel     = ctrl_r.wb_sel;
   assign x_ld       = ctrl_r.x_ld;
   assign y_ld       = ctrl_r.y_ld;
   assign alu_fsel   = ctrl_r.alu_fsel;
   assign alu_ld     = ctrl_r.alu_ld;
   assign flags      = flags_r;
   assign pc         = pc_r;
   assign ir         = ir_r;
   assign halted     = halted_r;
   assign illegal_op = illegal_r;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Self-checking bench for cpu_ctrl_fsm: datapath/memory model plus an event scoreboard.
`timescale 1ns/1ps
module tb_cpu_ctrl_fsm;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [15:0] mem_addr, mem_wdata, mem_rdata, reg_p, pc, ir, instr_cnt;
   logic        mem_rd, mem_wr, rb_rdr, rb_wrr, wb_sel, x_ld, y_ld, alu_ld, halted, illegal_op;
   logic [2:0]  rb_pa, rb_wp, alu_fsel;
   logic        alu_c, alu_v, alu_s, alu_z;
   logic [3:0]  flags;

   logic [15:0] mem_addr2, mem_wdata2, pc2, ir2, instr_cnt2;
   logic [15:0] mem_rdata2 = 16'h0000;
   logic [15:0] reg_p2 = 16'h0000;
   logic        mem_rd2, mem_wr2, rb_rdr2, rb_wrr2, wb_sel2, x_ld2, y_ld2, alu_ld2, halted2, illegal_op2;
   logic [2:0]  rb_pa2, rb_wp2, alu_fsel2;
   logic        alu_zero2 = 1'b0;
   logic [3:0]  flags2;

   cpu_ctrl_fsm dut (
      .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .reg_p(reg_p), .rb_pa(rb_pa),
      .rb_rdr(rb_rdr), .rb_wp(rb_wp), .rb_wrr(rb_wrr), .wb_sel(wb_sel), .x_ld(x_ld),
      .y_ld(y_ld), .alu_fsel(alu_fsel), .alu_ld(alu_ld), .alu_c(alu_c), .alu_v(alu_v),
      .alu_s(alu_s), .alu_z(alu_z), .flags(flags), .pc(pc), .ir(ir), .halted(halted),
      .illegal_op(illegal_op), .instr_cnt(instr_cnt)
   );

   cpu_ctrl_fsm #(.RESET_PC(16'hFFFE)) dut_wrap (
      .clk(clk), .rst(rst), .mem_addr(mem_addr2), .mem_rd(mem_rd2), .mem_wr(mem_wr2),
      .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata2), .reg_p(reg_p2), .rb_pa(rb_pa2),
      .rb_rdr(rb_rdr2), .rb_wp(rb_wp2), .rb_wrr(rb_wrr2), .wb_sel(wb_sel2), .x_ld(x_ld2),
      .y_ld(y_ld2), .alu_fsel(alu_fsel2), .alu_ld(alu_ld2), .alu_c(alu_zero2), .alu_v(alu_zero2),
      .alu_s(alu_zero2), .alu_z(alu_zero2), .flags(flags2), .pc(pc2), .ir(ir2), .halted(halted2),
      .illegal_op(illegal_op2), .instr_cnt(instr_cnt2)
   );

`ifdef CTRL_INSTR_CNT_EN
   localparam int EXP_CNT = 12;
   localparam int EXP_CNT2 = 1;
`else
   localparam int EXP_CNT = 0;
   localparam int EXP_CNT2 = 0;
`endif

   // Executed trace: fetch address, instruction word, flags expected while it is fetched
   localparam int N_TR = 12;
   logic [15:0] tr_pc  [N_TR] = '{16'h0000, 16'h0002, 16'h0004, 16'h0006, 16'h0008, 16'h0040,
                                 16'h0042, 16'h0044, 16'h0046, 16'h0048, 16'h004A, 16'h0080};
   logic [15:0] tr_ins [N_TR] = '{16'h1650, 16'h8128, 16'h7D00, 16'h6048, 16'hA1C0, 16'h6050,
                                 16'hA1C0, 16'hB000, 16'h5A40, 16'h0000, 16'h9000, 16'hF000};
   logic [3:0]  tr_flg [N_TR] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h1,
                                 4'hA, 4'hA, 4'hA, 4'hA, 4'hA, 4'hA};
   logic [15:0] init_regs [8] = '{16'h0080, 16'h0005, 16'h0007, 16'h0000,
                                  16'h0100, 16'hBEEF, 16'h0000, 16'h0040};

   // Datapath and memory model
   logic [15:0] rom [256];
   logic [15:0] regs [8];
   logic [15:0] data_w, x_r, y_r, alu_res;

   assign reg_p = regs[rb_pa];

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 8; i++) regs[i] <= init_regs[i];
         data_w <= 16'h0000; x_r <= 16'h0000; y_r <= 16'h0000; mem_rdata <= 16'h0000;
      end else begin
         if (mem_rd) mem_rdata <= (mem_addr == 16'h0100) ? data_w : rom[mem_addr[8:1]];
         if (mem_wr && (mem_addr == 16'h0100)) data_w <= mem_wdata;
         if (rb_wrr) regs[rb_wp] <= wb_sel ? mem_rdata : alu_res;
         if (x_ld) x_r <= reg_p;
         if (y_ld) y_r <= reg_p;
      end
   end

   always_comb begin
      alu_res = 16'h0000;
      alu_c = 1'b0;
      alu_v = 1'b0;
      case (alu_fsel)
         3'b000: begin
            {alu_c, alu_res} = {1'b0, x_r} + {1'b0, y_r};
            alu_v = (x_r[15] == y_r[15]) && (alu_res[15] != x_r[15]);
         end
         3'b001, 3'b101: begin
            alu_res = x_r - y_r;
            alu_c = x_r < y_r;
            alu_v = (x_r[15] != y_r[15]) && (alu_res[15] != x_r[15]);
         end
         3'b010: alu_res = x_r & y_r;
         3'b011: alu_res = x_r | y_r;
         3'b100: begin
            alu_res = 16'h0000 - x_r;
            alu_c = x_r != 16'h0000;
            alu_v = x_r == 16'h8000;
         end
         default: alu_res = 16'h0000;
      endcase
      alu_s = alu_res[15];
      alu_z = alu_res == 16'h0000;
   end

   int n_checks = 0;
   int n_errors = 0;
   int cyc;
   logic mon_en = 1'b0;

   always @(posedge clk or posedge rst) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Scoreboard event: {kind, v1, v2, cycle}
   typedef logic [63:0] ev_t;
   localparam logic [7:0] K_ILL = 8'd1, K_RD = 8'd2, K_WR = 8'd3, K_RR = 8'd4, K_AL = 8'd5, K_WB = 8'd6;
   ev_t exp_q[$];

   function automatic ev_t mk_ev(input logic [7:0] k, input logic [15:0] v1,
                                 input logic [15:0] v2, input int c);
      logic [23:0] c24;
      c24 = c[23:0];
      return {k, v1, v2, c24};
   endfunction

   task automatic take(input ev_t obs);
      if (exp_q.size() == 0) check_eq("sb_unexpected", obs, 64'h0);
      else check_eq("sb_event", obs, exp_q.pop_front());
   endtask

   always @(negedge clk) begin
      if (mon_en && !rst) begin
         if (illegal_op) take(mk_ev(K_ILL, 16'h0, 16'h0, cyc));
         if (mem_rd)     take(mk_ev(K_RD, mem_addr, {12'h0, flags}, cyc));
         if (mem_wr)     take(mk_ev(K_WR, mem_addr, mem_wdata, cyc));
         if (rb_rdr)     take(mk_ev(K_RR, {13'h0, rb_pa}, {14'h0, y_ld, x_ld}, cyc));
         if (alu_ld)     take(mk_ev(K_AL, {13'h0, alu_fsel}, 16'h0, cyc));
         if (rb_wrr)     take(mk_ev(K_WB, {13'h0, rb_wp}, {15'h0, wb_sel}, cyc));
      end
   end

   // Expected events of one instruction fetched at cycle f; f advances by its CPI.
   task automatic sched(input int idx, inout int f);
      logic [15:0] ins, addr;
      logic [3:0]  op;
      logic [2:0]  rd, rs1, rs2, fs;
      ins = tr_ins[idx];
      op = ins[15:12]; rd = ins[11:9]; rs1 = ins[8:6]; rs2 = ins[5:3];
      fs = (op == 4'h6) ? 3'b101 : (op == 4'h5) ? 3'b100 : 3'(op - 4'h1);
      addr = init_regs[rs1] & 16'hFFFE;
      exp_q.push_back(mk_ev(K_RD, tr_pc[idx], {12'h0, tr_flg[idx]}, f));
      if (op != 4'h0 && op < 4'hB) exp_q.push_back(mk_ev(K_RR, {13'h0, rs1}, 16'h1, f + 2));
      case (op)
         4'h1, 4'h2, 4'h3, 4'h4: begin
            exp_q.push_back(mk_ev(K_RR, {13'h0, rs2}, 16'h2, f + 3));
            exp_q.push_back(mk_ev(K_AL, {13'h0, fs}, 16'h0, f + 4));
            exp_q.push_back(mk_ev(K_AL, {13'h0, fs}, 16'h0, f + 5));
            exp_q.push_back(mk_ev(K_WB, {13'h0, rd}, 16'h0, f + 5));
            f += 6;
         end
         4'h5: begin
            exp_q.push_back(mk_ev(K_AL, {13'h0, fs}, 16'h0, f + 3));
            exp_q.push_back(mk_ev(K_AL, {13'h0, fs}, 16'h0, f + 4));
            exp_q.push_back(mk_ev(K_WB, {13'h0, rd}, 16'h0, f + 4));
            f += 5;
         end
         4'h6: begin
            exp_q.push_back(mk_ev(K_RR, {13'h0, rs2}, 16'h2, f + 3));
            exp_q.push_back(mk_ev(K_AL, {13'h0, fs}, 16'h0, f + 4));
            f += 5;
         end
         4'h7: begin
            exp_q.push_back(mk_ev(K_RD, addr, {12'h0, tr_flg[idx]}, f + 3));
            exp_q.push_back(mk_ev(K_WB, {13'h0, rd}, 16'h1, f + 4));
            f += 5;
         end
         4'h8: begin
            exp_q.push_back(mk_ev(K_RR, {13'h0, rs2}, 16'h2, f + 3));
            exp_q.push_back(mk_ev(K_WR, addr, init_regs[rs2], f + 4));
            f += 5;
         end
         4'h9, 4'hA: f += 3;
         4'hB, 4'hC, 4'hD, 4'hE: begin
            exp_q.push_back(mk_ev(K_ILL, 16'h0, 16'h0, f + 2));
            f += 2;
         end
         default: f += 2;
      endcase
   endtask

   task automatic wait_cyc(input int target);
      int n = 0;
      while (cyc != target && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (cyc != target) check_eq("wait_timeout", 64'(cyc), 64'(target));
   endtask

   logic [49:0] strobes;
   assign strobes = {mem_rd, mem_wr, rb_rdr, rb_wrr, wb_sel, x_ld, y_ld, alu_ld, illegal_op,
                     mem_addr, mem_wdata, rb_pa, rb_wp, alu_fsel};

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int f;
      int rd_in_halt;
      for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
      for (int i = 0; i < N_TR; i++) rom[tr_pc[i][8:1]] = tr_ins[i];
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      // Run into the EXEC cycle of the first ADD, then reset asynchronously.
      wait_cyc(5);
      check_eq("pre_exec_alu_ld", alu_ld, 1'b1);
      rst = 1'b1;
      #1;
      check_eq("rst_strobes", strobes, 50'h0);
      check_eq("rst_pc", pc, 16'h0000);
      check_eq("rst_ir", ir, 16'h0000);
      check_eq("rst_flags", flags, 4'h0);
      check_eq("rst_halted_cnt", {halted, instr_cnt}, 17'h0);
      @(negedge clk);
      check_eq("rst_hold_strobes", strobes, 50'h0);
      rst = 1'b0;
      f = 1;
      for (int i = 0; i < N_TR; i++) sched(i, f);
      mon_en = 1'b1;
      #1;
      check_eq("boot_strobes", strobes, 50'h0);
      wait_cyc(1);
      check_eq("wrap_fetch0", {mem_rd2, mem_addr2}, {1'b1, 16'hFFFE});
      wait_cyc(3);
      check_eq("wrap_fetch1", {mem_rd2, mem_addr2}, {1'b1, 16'h0000});
      check_eq("wrap_instr_cnt", instr_cnt2, 64'(EXP_CNT2));
      wait_cyc(f);
      check_eq("halt_flag", halted, 1'b1);
      check_eq("halt_pc", pc, 16'h0082);
      check_eq("halt_ir", ir, 16'hF000);
      check_eq("halt_instr_cnt", instr_cnt, 64'(EXP_CNT));
      check_eq("halt_strobes", strobes, 50'h0);
      rd_in_halt = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (mem_rd) rd_in_halt++;
      end
      check_eq("halt_no_fetch", 64'(rd_in_halt), 64'h0);
      check_eq("halt_stays", halted, 1'b1);
      check_eq("ld_result_r6", regs[6], 16'hBEEF);
      check_eq("st_mem_word", data_w, 16'hBEEF);
      check_eq("add_result_r3", regs[3], 16'h000C);
      check_eq("neg_result_r5", regs[5], 16'hFFFB);
      check_eq("sb_drained", 64'(exp_q.size()), 64'h0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
